constant_release_unit: RTL and testbench
========================================

Name: constant_release_unit

Overview:
- Producer-side counterpart of the dispatcher's constant scoreboard.
- Tracks in-flight constant-register write groups from the CGRA writeback path. When every lane write of a group has completed, it drives the one-cycle release pulse (wb_valid / wb_const_bitmap) that clears pending bits in the scoreboard.
- Bits still claimed by another in-flight group are withheld from the release, so the scoreboard is never cleared early.

Parameters:
- NUM_CONSTANT_REGS, 32: width of the constant-register bitmap.
- NUM_TAGS, 8: maximum number of concurrent write groups (tracking entries).
- CNT_W, 5: width of the per-group expected-write counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- alloc_valid  in  1  request to open a write group.
- alloc_ready  out  1  a free entry exists.
- alloc_const_map  in  NUM_CONSTANT_REGS  constants written by the group.
- alloc_num_writes  in  CNT_W  number of completions expected.
- alloc_tag  out  $clog2(NUM_TAGS)  tag assigned on handshake (combinational, valid when alloc_ready).
- done_valid  in  1  one write completion.
- done_tag  in  $clog2(NUM_TAGS)  group of that completion.
- wb_valid  out  1  release pulse to the scoreboard.
- wb_const_bitmap  out  NUM_CONSTANT_REGS  bits to release.
- inflight_cnt  out  $clog2(NUM_TAGS)+1  number of PENDING entries.
- err_stray_done  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Per-entry state FREE/PENDING, with registers map and remaining.
- Reset (async, rst=1): all entries FREE, map=0, remaining=0, wb_valid=0, wb_const_bitmap=0, inflight_cnt=0, err_stray_done=0. Reset mid-operation discards all groups; no release pulse is issued.
- Allocation:
  - alloc_ready = any entry FREE at cycle start.
  - alloc_tag = lowest-index FREE entry.
  - Handshake = alloc_valid & alloc_ready. It loads map and remaining=alloc_num_writes and sets the entry PENDING at the clock edge.
- Zero-write group (alloc_num_writes=0): the entry is loaded and completes in the same cycle. Release appears at t+1 and the entry never leaves FREE visibly.
- Completion:
  - done_valid with a PENDING tag decrements remaining.
  - A completion that brings remaining to 0 at cycle t completes the group. The entry goes FREE at the t edge and is allocatable from t+1.
- done_valid to a FREE tag, or to an entry whose remaining is already 0, is ignored. No state changes.
- Release (registered, 1-cycle latency):
  - comp_map = OR of maps completing in cycle t.
  - hold_map = OR of maps of entries PENDING after the t edge, including same-cycle allocations.
  - At t+1: wb_const_bitmap = comp_map & ~hold_map, and wb_valid = |that result.
  - Withheld bits are released when the last holding group completes.
  - Cycles with no release: wb_valid=0, wb_const_bitmap=0.
  - The scoreboard has no backpressure, so the pulse is fire-and-forget.
- Simultaneous events:
  - Only one done per cycle.
  - Allocation and completion may occur in the same cycle on different tags.
  - A tag completing in cycle t cannot be reallocated in cycle t.
- Width rules: remaining is CNT_W bits unsigned and never wraps (decrement is blocked at 0). inflight_cnt is updated as +1 on handshake and −1 on completion, both in the same cycle if both occur.

Optional Feature:
- Macro: CONST_REL_ERR_CHK_EN.
- Defined: err_stray_done is set sticky, clearable only by rst, on any ignored done. This covers a FREE tag, remaining==0, or done_tag ≥ NUM_TAGS. Simulation assertions also fire on alloc_valid&!alloc_ready being held with changing payload.
- Undefined: err_stray_done is tied 0 and no check logic or assertions are present. Ignored completions are still harmless.

Decomposition:
- Package dice_const_pkg holds:
  - NUM_CONSTANT_REGS default;
  - const_map_t;
  - const_tag_t;
  - entry_state_e {FREE, PENDING};
  - const_rel_entry_t struct {state, map, remaining}.
- One sub-module, const_rel_entry, instantiated NUM_TAGS times. It holds a single entry's state and counter and outputs pending, completing and map.

Test Plan:
1. Allocate map=0x0000_000F, num_writes=3 → tag 0. Issue 3 dones on tag 0 → wb_valid=1 with bitmap 0x0000000F exactly one cycle after the 3rd done; inflight_cnt returns to 0.
2. Allocate num_writes=0 with map=0x10 → wb_valid=1, bitmap 0x10 in the next cycle; alloc_ready never drops.
3. Tag0 map=0x3 (1 write), tag1 map=0x6 (1 write). Complete tag0 → bitmap 0x1. Then complete tag1 → bitmap 0x6.
4. Fill all 8 tags → alloc_ready=0. Complete tag 5 → alloc_ready=1 and alloc_tag=5 in the next cycle. Same-cycle alloc plus done on another tag keeps inflight_cnt unchanged.
5. Issue done to a FREE tag 3 → no wb pulse and no state change. err_stray_done=1 with CONST_REL_ERR_CHK_EN, 0 without.
6. Assert rst while 4 groups are pending → all outputs 0 immediately. After deassertion, alloc_tag=0 and no release pulse occurs.

Source files
------------

// File: rtl/dice_const_pkg.sv
// Purpose: shared types for the constant-register release path (maps, tags, entry state).
// Latency: n/a (types and default sizes only).
// Backpressure: n/a.
package dice_const_pkg;

    localparam int NUM_CONSTANT_REGS_DFLT = 32;
    localparam int NUM_TAGS_DFLT          = 8;
    localparam int CNT_W_DFLT             = 5;
    localparam int TAG_W_DFLT             = $clog2(NUM_TAGS_DFLT);

    typedef logic [NUM_CONSTANT_REGS_DFLT-1:0] const_map_t;
    typedef logic [TAG_W_DFLT-1:0]             const_tag_t;

    typedef enum logic {
        FREE    = 1'b0,
        PENDING = 1'b1
    } entry_state_e;

    // Snapshot of one tracking entry at the default sizes.
    typedef struct packed {
        entry_state_e            state;
        const_map_t              map;
        logic [CNT_W_DFLT-1:0]   remaining;
    } const_rel_entry_t;

endpackage

// File: rtl/const_rel_entry.sv
// Purpose: one write-group tracking entry (state, constant map, remaining-write counter).
// Latency: completion is flagged combinationally in the cycle of the final write; state updates at the edge.
// Backpressure: none; load only targets a FREE entry, dec only counts when the entry can accept it.
//
// Ports: clk, rst (async active-high); load/load_map/load_num open a group;
// dec is one accepted completion; pending/accept report current state;
// completing/comp_map flag the group finishing this cycle; hold_map is the
// map this entry still claims after the coming edge.
module const_rel_entry
    import dice_const_pkg::*;
#(
    parameter int MAP_W = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [MAP_W-1:0] load_map,
    input  logic [CNT_W-1:0] load_num,
    input  logic             dec,
    output logic             pending,
    output logic             accept,
    output logic             completing,
    output logic [MAP_W-1:0] comp_map,
    output logic [MAP_W-1:0] hold_map
);

    entry_state_e     state_q, state_d;
    logic [MAP_W-1:0] map_q, map_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    assign pending = (state_q == PENDING);
    // A PENDING entry always has remaining >= 1; the zero test keeps the
    // counter from ever wrapping even if that invariant were broken.
    assign accept  = pending && (rem_q != '0);

    always_comb begin
        state_d    = state_q;
        map_d      = map_q;
        rem_d      = rem_q;
        completing = 1'b0;
        comp_map   = '0;
        if (load) begin
            if (load_num == '0) begin
                // Zero-write group finishes in its own allocation cycle and
                // never becomes visibly PENDING.
                completing = 1'b1;
                comp_map   = load_map;
                map_d      = '0;
                rem_d      = '0;
            end else begin
                state_d = PENDING;
                map_d   = load_map;
                rem_d   = load_num;
            end
        end else if (dec && accept) begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
                completing = 1'b1;
                comp_map   = map_q;
                state_d    = FREE;
                map_d      = '0;
            end
        end
    end

    assign hold_map = (state_d == PENDING) ? map_d : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FREE;
            map_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            map_q   <= map_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: rtl/constant_release_unit.sv
// Purpose: track in-flight constant write groups and pulse the scoreboard release when a group completes.
// Latency: release pulse one cycle after the completing write (or after a zero-write allocation).
// Backpressure: alloc_ready drops when all entries are PENDING; release pulse is fire-and-forget.
//
// Ports: clk, rst (async active-high); alloc_valid/alloc_ready/alloc_const_map/
// alloc_num_writes/alloc_tag open a group; done_valid/done_tag report one lane
// write; wb_valid/wb_const_bitmap release scoreboard bits; inflight_cnt counts
// PENDING entries; err_stray_done flags ignored completions.
// Optional: CONST_REL_ERR_CHK_EN enables the sticky stray-done flag and the
// alloc payload stability assertion; without it err_stray_done is tied low.
module constant_release_unit
    import dice_const_pkg::*;
#(
    parameter int NUM_CONSTANT_REGS = NUM_CONSTANT_REGS_DFLT,
    parameter int NUM_TAGS          = NUM_TAGS_DFLT,
    parameter int CNT_W             = CNT_W_DFLT,
    parameter int TAG_W             = $clog2(NUM_TAGS),
    parameter int INF_W             = $clog2(NUM_TAGS) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  logic [NUM_CONSTANT_REGS-1:0] alloc_const_map,
    input  logic [CNT_W-1:0]             alloc_num_writes,
    output logic [TAG_W-1:0]             alloc_tag,
    input  logic                         done_valid,
    input  logic [TAG_W-1:0]             done_tag,
    output logic                         wb_valid,
    output logic [NUM_CONSTANT_REGS-1:0] wb_const_bitmap,
    output logic [INF_W-1:0]             inflight_cnt,
    output logic                         err_stray_done
);

    logic [NUM_TAGS-1:0]          pending_vec;
    logic [NUM_TAGS-1:0]          accept_vec;
    logic [NUM_TAGS-1:0]          completing_vec;
    logic [NUM_TAGS-1:0]          load_vec;
    logic [NUM_TAGS-1:0]          dec_vec;
    logic [NUM_CONSTANT_REGS-1:0] comp_map_arr [NUM_TAGS];
    logic [NUM_CONSTANT_REGS-1:0] hold_map_arr [NUM_TAGS];

    logic                         alloc_hs;
    logic                         free_found;
    logic [NUM_CONSTANT_REGS-1:0] comp_any;
    logic [NUM_CONSTANT_REGS-1:0] hold_any;
    logic [NUM_CONSTANT_REGS-1:0] rel_map;
    logic [INF_W-1:0]             n_comp;
    logic [INF_W-1:0]             inflight_q;

    // Allocation picks the lowest FREE entry as of cycle start, so an entry
    // completing this cycle cannot be handed out again until the next cycle.
    assign alloc_ready = ~(&pending_vec);
    assign alloc_hs    = alloc_valid && alloc_ready;

    always_comb begin
        alloc_tag  = '0;
        free_found = 1'b0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (!pending_vec[i] && !free_found) begin
                alloc_tag  = TAG_W'(i);
                free_found = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_TAGS; g++) begin : g_entry
        assign load_vec[g] = alloc_hs && (alloc_tag == TAG_W'(g));
        // Only completions the entry can actually absorb count; anything else
        // (FREE tag, exhausted counter, out-of-range tag) matches no entry.
        assign dec_vec[g]  = done_valid && (done_tag == TAG_W'(g)) && accept_vec[g];

        const_rel_entry #(
            .MAP_W (NUM_CONSTANT_REGS),
            .CNT_W (CNT_W)
        ) u_entry (
            .clk        (clk),
            .rst        (rst),
            .load       (load_vec[g]),
            .load_map   (alloc_const_map),
            .load_num   (alloc_num_writes),
            .dec        (dec_vec[g]),
            .pending    (pending_vec[g]),
            .accept     (accept_vec[g]),
            .completing (completing_vec[g]),
            .comp_map   (comp_map_arr[g]),
            .hold_map   (hold_map_arr[g])
        );
    end

    // Bits still claimed by any group PENDING after this edge (including a
    // group allocated this very cycle) are withheld from the release.
    always_comb begin
        comp_any = '0;
        hold_any = '0;
        n_comp   = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            comp_any = comp_any | comp_map_arr[i];
            hold_any = hold_any | hold_map_arr[i];
            n_comp   = n_comp + INF_W'(completing_vec[i]);
        end
    end

    assign rel_map = comp_any & ~hold_any;

    // Zero-write groups count +1 and -1 in the same cycle, leaving the
    // count equal to the number of visibly PENDING entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid        <= 1'b0;
            wb_const_bitmap <= '0;
            inflight_q      <= '0;
        end else begin
            wb_valid        <= |rel_map;
            wb_const_bitmap <= rel_map;
            inflight_q      <= inflight_q + INF_W'(alloc_hs) - n_comp;
        end
    end

    assign inflight_cnt = inflight_q;

`ifdef CONST_REL_ERR_CHK_EN
    logic stray_done;
    logic err_q;

    assign stray_done = done_valid && !(|dec_vec);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (stray_done) begin
            err_q <= 1'b1;
        end
    end

    assign err_stray_done = err_q;

    // A stalled allocation request must keep its payload until accepted.
    a_alloc_stable : assert property (
        @(posedge clk) disable iff (rst)
        (alloc_valid && !alloc_ready) |=>
            (!alloc_valid || ($stable(alloc_const_map) && $stable(alloc_num_writes)))
    );
`else
    assign err_stray_done = 1'b0;
`endif

endmodule

// File: tb/tb_constant_release_unit.sv
module tb_constant_release_unit;

    localparam int NR = 32;
    localparam int NT = 8;
    localparam int CW = 5;
    localparam int TW = 3;
    localparam int IW = 4;

    logic          clk;
    logic          rst;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [NR-1:0] alloc_const_map;
    logic [CW-1:0] alloc_num_writes;
    logic [TW-1:0] alloc_tag;
    logic          done_valid;
    logic [TW-1:0] done_tag;
    logic          wb_valid;
    logic [NR-1:0] wb_const_bitmap;
    logic [IW-1:0] inflight_cnt;
    logic          err_stray_done;

    constant_release_unit #(
        .NUM_CONSTANT_REGS (NR),
        .NUM_TAGS          (NT),
        .CNT_W             (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_valid      (alloc_valid),
        .alloc_ready      (alloc_ready),
        .alloc_const_map  (alloc_const_map),
        .alloc_num_writes (alloc_num_writes),
        .alloc_tag        (alloc_tag),
        .done_valid       (done_valid),
        .done_tag         (done_tag),
        .wb_valid         (wb_valid),
        .wb_const_bitmap  (wb_const_bitmap),
        .inflight_cnt     (inflight_cnt),
        .err_stray_done   (err_stray_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int            cyc;
        logic [NR-1:0] map;
    } exp_t;

    exp_t exp_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [NR-1:0] m, input logic [CW-1:0] n,
                         input logic dv, input logic [TW-1:0] dt);
        alloc_valid      = av;
        alloc_const_map  = m;
        alloc_num_writes = n;
        done_valid       = dv;
        done_tag         = dt;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0);
    endtask

    // Called while the stimulus for cycle cyc is on the pins: the release
    // must be visible during the following cycle only.
    task automatic expect_rel(input logic [NR-1:0] m);
        exp_t e;
        e.cyc = cyc + 1;
        e.map = m;
        exp_q.push_back(e);
    endtask

    // Release monitor: every enabled cycle either matches the scoreboard
    // head or must show an idle release interface.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (mon_en) begin
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_val("wb_valid", 64'(wb_valid), 64'd1);
                    check_val("wb_bitmap", 64'(wb_const_bitmap), 64'(e.map));
                end else begin
                    check_val("wb_idle", {31'd0, wb_valid, wb_const_bitmap}, 64'd0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int   drain_tags[5] = '{1, 3, 4, 6, 7};
        logic exp_err;

        rst = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_wb_valid", 64'(wb_valid), 64'd0);
        check_val("rst_wb_bitmap", 64'(wb_const_bitmap), 64'd0);
        check_val("rst_inflight", 64'(inflight_cnt), 64'd0);
        check_val("rst_err", 64'(err_stray_done), 64'd0);
        check_val("rst_ready", 64'(alloc_ready), 64'd1);
        check_val("rst_tag", 64'(alloc_tag), 64'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // 1: three-write group on tag 0
        step(); drive(1'b1, 32'h0000_000F, 5'd3, 1'b0, 3'd0); #1;
        check_val("t1_ready", 64'(alloc_ready), 64'd1);
        check_val("t1_tag", 64'(alloc_tag), 64'd0);
        step(); drive(1'b0, '0, '0, 1'b1, 3'd0); #1;
        check_val("t1_inflight1", 64'(inflight_cnt), 64'd1);
        step(); drive(1'b0, '0, '0, 1'b1, 3'd0);
        step(); drive(1'b0, '0, '0, 1'b1, 3'd0); expect_rel(32'h0000_000F);
        step(); idle(); #1;
        check_val("t1_inflight0", 64'(inflight_cnt), 64'd0);

        // 2: zero-write group releases next cycle, ready never drops
        step(); drive(1'b1, 32'h10, 5'd0, 1'b0, 3'd0); expect_rel(32'h10); #1;
        check_val("t2_ready", 64'(alloc_ready), 64'd1);
        check_val("t2_tag", 64'(alloc_tag), 64'd0);
        step(); idle(); #1;
        check_val("t2_ready_after", 64'(alloc_ready), 64'd1);
        check_val("t2_inflight", 64'(inflight_cnt), 64'd0);
        check_val("t2_tag_after", 64'(alloc_tag), 64'd0);

        // 3: overlapping maps withhold shared bit
        step(); drive(1'b1, 32'h3, 5'd1, 1'b0, 3'd0); #1;
        check_val("t3_tag0", 64'(alloc_tag), 64'd0);
        step(); drive(1'b1, 32'h6, 5'd1, 1'b0, 3'd0); #1;
        check_val("t3_tag1", 64'(alloc_tag), 64'd1);
        step(); drive(1'b0, '0, '0, 1'b1, 3'd0); expect_rel(32'h1); #1;
        check_val("t3_inflight2", 64'(inflight_cnt), 64'd2);
        step(); drive(1'b0, '0, '0, 1'b1, 3'd1); expect_rel(32'h6);
        step(); idle(); #1;
        check_val("t3_inflight0", 64'(inflight_cnt), 64'd0);

        // 4: fill all tags, free one, same-cycle alloc + done, withhold
        for (int i = 0; i < NT; i++) begin
            step(); drive(1'b1, 32'h100 << i, 5'd1, 1'b0, 3'd0); #1;
            check_val("t4_fill_tag", 64'(alloc_tag), 64'(i));
        end
        step(); idle(); #1;
        check_val("t4_full_ready", 64'(alloc_ready), 64'd0);
        check_val("t4_full_inflight", 64'(inflight_cnt), 64'd8);
        step(); drive(1'b0, '0, '0, 1'b1, 3'd5); expect_rel(32'h100 << 5);
        step(); drive(1'b1, 32'h0010_0100, 5'd1, 1'b1, 3'd2); expect_rel(32'h100 << 2); #1;
        check_val("t4_ready_again", 64'(alloc_ready), 64'd1);
        check_val("t4_tag5", 64'(alloc_tag), 64'd5);
        check_val("t4_inflight7", 64'(inflight_cnt), 64'd7);
        step(); drive(1'b0, '0, '0, 1'b1, 3'd0); #1;
        check_val("t4_inflight_same", 64'(inflight_cnt), 64'd7);
        check_val("t4_tag2", 64'(alloc_tag), 64'd2);
        step(); drive(1'b0, '0, '0, 1'b1, 3'd5); expect_rel(32'h0010_0100); #1;
        check_val("t4_inflight6", 64'(inflight_cnt), 64'd6);
        foreach (drain_tags[k]) begin
            step(); drive(1'b0, '0, '0, 1'b1, 3'(drain_tags[k])); expect_rel(32'h100 << drain_tags[k]);
        end
        step(); idle(); #1;
        check_val("t4_inflight0", 64'(inflight_cnt), 64'd0);

        // 5: stray done to a FREE tag
        step(); drive(1'b0, '0, '0, 1'b1, 3'd3);
        step(); idle(); #1;
`ifdef CONST_REL_ERR_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        check_val("t5_err", 64'(err_stray_done), 64'(exp_err));
        check_val("t5_inflight", 64'(inflight_cnt), 64'd0);
        check_val("t5_tag", 64'(alloc_tag), 64'd0);

        // 6: reset with four pending groups and a completion in flight
        for (int i = 0; i < 4; i++) begin
            step(); drive(1'b1, 32'h1 << i, 5'd1, 1'b0, 3'd0);
        end
        step(); drive(1'b0, '0, '0, 1'b1, 3'd0); #1;
        check_val("t6_inflight4", 64'(inflight_cnt), 64'd4);
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        check_val("t6_rst_wb", {31'd0, wb_valid, wb_const_bitmap}, 64'd0);
        check_val("t6_rst_inflight", 64'(inflight_cnt), 64'd0);
        check_val("t6_rst_err", 64'(err_stray_done), 64'd0);
        check_val("t6_rst_ready", 64'(alloc_ready), 64'd1);
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        #1;
        check_val("t6_tag0", 64'(alloc_tag), 64'd0);
        check_val("t6_inflight0", 64'(inflight_cnt), 64'd0);
        repeat (3) step();

        check_val("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
